// File: rtl/stepper_drive.sv
// Two-wheel stepper sequencer: accepts a step command, paces wave-drive coil
// phases with a per-command divider and reports busy/done back to the requester.
module stepper_drive #(
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned DIV_W    = 20,
  parameter int unsigned FAST_DIV = 200000,
  parameter int unsigned SLOW_DIV = 400000,
  parameter int unsigned HOLD     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir_left,
  input  logic              cmd_dir_right,
  input  logic              speed,
  input  logic              abort,
  output logic [3:0]        motor_left,
  output logic [3:0]        motor_right,
  output logic              locked,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  localparam logic [DIV_W-1:0]  FAST_CNT = DIV_W'(FAST_DIV);
  localparam logic [DIV_W-1:0]  SLOW_CNT = DIV_W'(SLOW_DIV);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [1:0]        pl_q, pl_d, pr_q, pr_d;
  logic              dl_q, dl_d, dr_q, dr_d;
  logic              energ_q, energ_d;
  logic              ready_en_q;
  logic              done_q;
  logic              accept;
  logic              tick;

  assign accept = cmd_valid && cmd_ready;
  // abort masks the tick so a coincident abort never advances the coils
  assign tick   = (state_q == S_RUN) && !abort && (cnt_q == div_q - DIV_ONE);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (cmd_steps != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (abort)                               state_d = S_DONE;
        else if (tick && (steps_q == STEP_ONE))  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    pl_d    = pl_q;
    pr_d    = pr_q;
    dl_d    = dl_q;
    dr_d    = dr_q;
    energ_d = energ_q;
    if (accept) begin
      dl_d    = cmd_dir_left;
      dr_d    = cmd_dir_right;
      div_d   = speed ? FAST_CNT : SLOW_CNT;
      steps_d = cmd_steps;
      cnt_d   = '0;
    end else if (tick) begin
      cnt_d   = '0;
      steps_d = steps_q - STEP_ONE;
      pl_d    = dl_q ? pl_q + 2'd1 : pl_q - 2'd1;
      pr_d    = dr_q ? pr_q + 2'd1 : pr_q - 2'd1;
      energ_d = 1'b1;
    end else if ((state_q == S_RUN) && !abort) begin
      cnt_d   = cnt_q + DIV_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      cnt_q      <= '0;
      steps_q    <= '0;
      pl_q       <= '0;
      pr_q       <= '0;
      dl_q       <= 1'b0;
      dr_q       <= 1'b0;
      energ_q    <= 1'b0;
      ready_en_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      steps_q    <= steps_d;
      pl_q       <= pl_d;
      pr_q       <= pr_d;
      dl_q       <= dl_d;
      dr_q       <= dr_d;
      energ_q    <= energ_d;
      ready_en_q <= 1'b1;
      done_q     <= (state_q == S_DONE);
    end
  end

  // coils stay dark until the first step has ever been taken since reset
  always_comb begin
    cmd_ready   = 1'b0;
    locked      = 1'b0;
    motor_left  = '0;
    motor_right = '0;
    case (state_q)
      S_IDLE:  cmd_ready = ready_en_q;
      S_RUN:   locked    = 1'b1;
      default: ;
    endcase
    if (energ_q && ((state_q == S_RUN) || (HOLD != 0))) begin
      motor_left  = 4'b0001 << pl_q;
      motor_right = 4'b0001 << pr_q;
    end
  end

  assign done       = done_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_stepper_drive.sv
// Scoreboard bench for stepper_drive: each command pushes its expected output
// events (coil/locked/done changes with cycle stamps); a monitor pops and compares.
module tb_stepper_drive;

  localparam int FAST = 4;
  localparam int SLOW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir_left;
  logic        cmd_dir_right;
  logic        speed;
  logic        abort;
  logic [3:0]  motor_left;
  logic [3:0]  motor_right;
  logic        locked;
  logic        done;
  logic [15:0] steps_left;

  stepper_drive #(
    .STEP_W   (16),
    .DIV_W    (20),
    .FAST_DIV (FAST),
    .SLOW_DIV (SLOW),
    .HOLD     (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_steps     (cmd_steps),
    .cmd_dir_left  (cmd_dir_left),
    .cmd_dir_right (cmd_dir_right),
    .speed         (speed),
    .abort         (abort),
    .motor_left    (motor_left),
    .motor_right   (motor_right),
    .locked        (locked),
    .done          (done),
    .steps_left    (steps_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  ml;
    logic [3:0]  mr;
    logic [15:0] sl;
    logic        lk;
    logic        dn;
  } ev_t;

  ev_t  evq[$];
  ev_t  e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en = 1'b0;
  logic [3:0] pml, pmr;
  logic       plk;

  // reference phase model
  logic [1:0] m_pl, m_pr;
  logic       m_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] coil(input logic [1:0] p, input logic en);
    return en ? (4'b0001 << p) : 4'b0000;
  endfunction

  task automatic push_ev(input int c, input logic [15:0] sl, input logic lk, input logic dn);
    ev_t x;
    x.cyc = c; x.ml = coil(m_pl, m_en); x.mr = coil(m_pr, m_en);
    x.sl = sl; x.lk = lk; x.dn = dn;
    evq.push_back(x);
  endtask

  // ab = edge offset after accept at which abort is sampled (0 = no abort)
  task automatic push_cmd(input int acc, input int n, input logic dl, input logic dr,
                          input int d, input int ab);
    int nst, term;
    if (n == 0) begin
      push_ev(acc + 1, 16'd0, 1'b0, 1'b1);
      return;
    end
    nst  = n;
    term = n * d;
    if (ab > 0 && ab <= n * d) begin
      nst  = (ab - 1) / d;
      term = ab;
    end
    push_ev(acc, 16'(n), 1'b1, 1'b0);
    for (int k = 1; k <= nst; k++) begin
      m_pl = dl ? m_pl + 2'd1 : m_pl - 2'd1;
      m_pr = dr ? m_pr + 2'd1 : m_pr - 2'd1;
      m_en = 1'b1;
      push_ev(acc + k * d, 16'(n - k), (k * d != term), 1'b0);
    end
    if (term != n * d || nst != n) push_ev(acc + term, 16'(n - nst), 1'b0, 1'b0);
    push_ev(acc + term + 1, 16'(n - nst), 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (motor_left !== pml || motor_right !== pmr || locked !== plk || done !== 1'b0) begin
        if (evq.size() == 0) begin
          check("spurious_evt_cyc", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = evq.pop_front();
          check("evt_cycle",  32'(cyc), 32'(e.cyc));
          check("motor_left", motor_left, e.ml);
          check("motor_right", motor_right, e.mr);
          check("steps_left", steps_left, e.sl);
          check("locked",     locked, e.lk);
          check("done",       done, e.dn);
        end
      end
      pml = motor_left;
      pmr = motor_right;
      plk = locked;
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_steps = '0; cmd_dir_left = 1'b0; cmd_dir_right = 1'b0; speed = 1'b0;
    repeat (3) tick();
    check("rst_motor_left", motor_left, 4'b0000);
    check("rst_motor_right", motor_right, 4'b0000);
    check("rst_locked", locked, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_steps_left", steps_left, 16'd0);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b1;
    #1 check("ready_before_release_edge", cmd_ready, 1'b0);
    tick();
    check("ready_after_release", cmd_ready, 1'b1);
    m_pl = 2'd0; m_pr = 2'd0; m_en = 1'b0;
    evq.delete();
    pml = 4'b0000; pmr = 4'b0000; plk = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && evq.size() != 0; i++) tick();
    check(tag, 32'(evq.size()), 32'd0);
    tick();
  endtask

  task automatic run_cmd(input int n, input logic dl, input logic dr, input logic spd,
                         input int ab, input string tag);
    int acc;
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_steps = 16'(n);
    cmd_dir_left = dl; cmd_dir_right = dr; speed = spd;
    acc = cyc + 1;
    push_cmd(acc, n, dl, dr, spd ? FAST : SLOW, ab);
    tick();
    // scramble inputs after acceptance; the running command must ignore them
    cmd_valid = 1'b0; cmd_steps = 16'($urandom);
    cmd_dir_left = ~dl; cmd_dir_right = ~dr; speed = ~spd;
    if (ab > 0) begin
      while (cyc < acc + ab - 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    wait_drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc1, acc2;
    do_reset();

    // forward: 0010,0100,1000,0001,0010 at +4..+20, done at +21
    run_cmd(5, 1'b1, 1'b1, 1'b1, 0, "drain_forward");
    check("forward_steps_left", steps_left, 16'd0);

    // mixed directions from a fresh reset, slow pacing
    do_reset();
    run_cmd(3, 1'b1, 1'b0, 1'b0, 0, "drain_mixed");

    // zero steps: done at +1, no locked, coils held
    run_cmd(0, 1'b0, 1'b1, 1'b1, 0, "drain_zero");
    check("zero_hold_left", motor_left, 4'b1000);
    check("zero_hold_right", motor_right, 4'b0010);

    // abort coincident with the second tick
    run_cmd(10, 1'b1, 1'b0, 1'b1, 8, "drain_abort");
    check("abort_steps_left", steps_left, 16'd9);
    check("abort_back_idle", cmd_ready, 1'b1);

    // abort in IDLE is ignored
    abort = 1'b1; tick(); tick(); abort = 1'b0;
    check("idle_abort_ready", cmd_ready, 1'b1);

    // back-to-back with cmd_valid held across completion
    cmd_valid = 1'b1; cmd_steps = 16'd2;
    cmd_dir_left = 1'b1; cmd_dir_right = 1'b1; speed = 1'b1;
    acc1 = cyc + 1;
    push_cmd(acc1, 2, 1'b1, 1'b1, FAST, 0);
    acc2 = acc1 + 2 * FAST + 2;
    push_cmd(acc2, 3, 1'b0, 1'b1, SLOW, 0);
    tick();
    cmd_steps = 16'd3; cmd_dir_left = 1'b0; cmd_dir_right = 1'b1; speed = 1'b0;
    for (int i = 0; i < 100 && cyc < acc2; i++) tick();
    cmd_valid = 1'b0; cmd_steps = 16'd7; speed = 1'b1;
    wait_drain("drain_b2b");
    check("b2b_steps_left", steps_left, 16'd0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
